// File: rtl/chart_read_arbiter.sv
// chart_read_arbiter: shares the chart note memory among UI pages, one read in flight at a time.
// Optional: define CHART_ARB_PLAY_PRIORITY_EN to let requester 0 (play page) pre-empt round-robin.
module chart_read_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int CHARTS_MAX      = 8,
  parameter int NOTES_PER_CHART = 64,
  parameter int IDX_W           = 6,
  parameter int DATA_W          = 16,
  parameter int ADDR_W          = 9,
  parameter int MEM_LAT         = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*8-1:0]     req_chart_id,
  input  logic [NUM_REQ*IDX_W-1:0] req_note_idx,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rerr,
  output logic                     busy,
  output logic                     mem_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_rdata
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rerr;
  logic                r_busy;
  logic                r_mem_en;
  logic [ADDR_W-1:0]   r_mem_addr;

  logic [NUM_REQ-1:0][7:0]       w_ids;
  logic [NUM_REQ-1:0][IDX_W-1:0] w_notes;
  logic [NUM_REQ-1:0]            w_req_rr;
  logic                          w_found;
  logic [PTR_W-1:0]              w_win;
  logic [PTR_W-1:0]              w_ptr_nxt;
  logic [7:0]                    w_sel_id;
  logic [IDX_W-1:0]              w_sel_note;
  logic                          w_inrange;
  logic [ADDR_W-1:0]             w_addr;

  assign w_ids   = req_chart_id;
  assign w_notes = req_note_idx;

  always_comb begin
    w_req_rr = req;
`ifdef CHART_ARB_PLAY_PRIORITY_EN
    w_req_rr[0] = 1'b0;
`endif
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_req_rr[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
    w_ptr_nxt = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + PTR_W'(1);
`ifdef CHART_ARB_PLAY_PRIORITY_EN
    // Play page bypasses the rotation and leaves the pointer where it was.
    if (req[0]) begin
      w_win     = '0;
      w_ptr_nxt = r_ptr;
    end
`endif
  end

  assign w_sel_id   = w_ids[w_win];
  assign w_sel_note = w_notes[w_win];
  assign w_inrange  = int'(w_sel_id) < CHARTS_MAX;
  assign w_addr     = ADDR_W'(int'(w_sel_id) * NOTES_PER_CHART + int'(w_sel_note));

  // RESP also arbitrates so back-to-back reads run at one per MEM_LAT+2 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_gnt      <= '0;
      r_rvalid   <= '0;
      r_rdata    <= '0;
      r_rerr     <= 1'b0;
      r_busy     <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_mem_en <= 1'b0;
      case (r_state)
        S_IDLE, S_RESP: begin
          if (|req) begin
            r_gnt[w_win] <= 1'b1;
            r_idx        <= w_win;
            r_ptr        <= w_ptr_nxt;
            r_err        <= !w_inrange;
            r_mem_en     <= w_inrange;
            if (w_inrange) r_mem_addr <= w_addr;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
            r_state      <= S_WAIT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_cnt == CNT_W'(MEM_LAT)) begin
            r_rdata         <= r_err ? '0 : mem_rdata;
            r_rerr          <= r_err;
            r_rvalid[r_idx] <= 1'b1;
            r_state         <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign rvalid   = r_rvalid;
  assign rdata    = r_rdata;
  assign rerr     = r_rerr;
  assign busy     = r_busy;
  assign mem_en   = r_mem_en;
  assign mem_addr = r_mem_addr;
endmodule

// File: tb/tb_chart_read_arbiter.sv
// Scoreboard bench for chart_read_arbiter: a per-cycle request model predicts grants and responses;
// a negedge monitor compares them against the DUT. Honours CHART_ARB_PLAY_PRIORITY_EN.
module tb_chart_read_arbiter;
  localparam int NUM_REQ = 4, CHARTS_MAX = 8, NOTES = 64, IDX_W = 6;
  localparam int DATA_W = 16, ADDR_W = 9, MEM_LAT = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*8-1:0]     req_chart_id;
  logic [NUM_REQ*IDX_W-1:0] req_note_idx;
  logic [NUM_REQ-1:0]       gnt, rvalid;
  logic [DATA_W-1:0]        rdata, mem_rdata;
  logic                     rerr, busy, mem_en;
  logic [ADDR_W-1:0]        mem_addr;

  chart_read_arbiter #(
    .NUM_REQ(NUM_REQ), .CHARTS_MAX(CHARTS_MAX), .NOTES_PER_CHART(NOTES), .IDX_W(IDX_W),
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_chart_id(req_chart_id), .req_note_idx(req_note_idx),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .rerr(rerr), .busy(busy),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: data valid exactly MEM_LAT cycles after mem_en, junk otherwise.
  logic [DATA_W-1:0] mem [512];
  logic [DATA_W-1:0] pd  [MEM_LAT];
  logic              pv  [MEM_LAT];
  logic [DATA_W-1:0] junk;
  always @(posedge clk) begin
    junk  <= DATA_W'($urandom);
    pv[0] <= mem_en;
    pd[0] <= mem[mem_addr];
    for (int i = 1; i < MEM_LAT; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end
  assign mem_rdata = pv[MEM_LAT-1] ? pd[MEM_LAT-1] : junk;

  typedef struct { int c; logic [NUM_REQ-1:0] oh; logic en; logic [ADDR_W-1:0] addr; } gexp_t;
  typedef struct { int c; logic [NUM_REQ-1:0] oh; logic [DATA_W-1:0] d; logic e; } rexp_t;
  typedef struct { int lo; int hi; } bexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  bexp_t bq[$];

  int n_checks = 0, n_fail = 0;
  logic mon_en = 1'b0;
  logic [DATA_W-1:0] last_rdata = '0;
  int m_ptr = 0, next_arb = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: one arbitration whenever the arbiter is free and anyone is asking.
  task automatic model_step();
    int w, id, note, tg;
    gexp_t g;
    rexp_t r;
    bexp_t b;
    if (cyc < next_arb || req == '0) return;
    w = -1;
`ifdef CHART_ARB_PLAY_PRIORITY_EN
    if (req[0]) w = 0;
`endif
    if (w < 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int j;
        j = (m_ptr + k) % NUM_REQ;
`ifdef CHART_ARB_PLAY_PRIORITY_EN
        if (j == 0) continue;
`endif
        if (w < 0 && req[j]) begin
          w = j;
          m_ptr = (j + 1) % NUM_REQ;
        end
      end
    end
    id   = int'(req_chart_id[8*w +: 8]);
    note = int'(req_note_idx[IDX_W*w +: IDX_W]);
    tg   = cyc + 1;
    g.c = tg; g.oh = NUM_REQ'(1) << w; g.en = id < CHARTS_MAX; g.addr = ADDR_W'(id * NOTES + note);
    r.c = tg + MEM_LAT + 1; r.oh = g.oh; r.e = !g.en;
    r.d = g.en ? mem[id * NOTES + note] : '0;
    b.lo = tg; b.hi = tg + MEM_LAT + 1;
    gq.push_back(g);
    rq.push_back(r);
    bq.push_back(b);
    next_arb = tg + MEM_LAT + 1;
  endtask

  gexp_t m_g;
  rexp_t m_r;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (gq.size() != 0 && gq[0].c == cyc) begin
        m_g = gq.pop_front();
        chk("gnt", 64'(gnt), 64'(m_g.oh));
        chk("mem_en", 64'(mem_en), 64'(m_g.en));
        if (m_g.en) chk("mem_addr", 64'(mem_addr), 64'(m_g.addr));
      end else begin
        chk("gnt_idle", 64'({gnt, mem_en}), 64'(0));
      end
      if (rq.size() != 0 && rq[0].c == cyc) begin
        m_r = rq.pop_front();
        chk("rvalid", 64'(rvalid), 64'(m_r.oh));
        chk("rdata", 64'(rdata), 64'(m_r.d));
        chk("rerr", 64'(rerr), 64'(m_r.e));
        last_rdata = m_r.d;
      end else begin
        chk("rvalid_idle", 64'(rvalid), 64'(0));
        chk("rdata_hold", 64'(rdata), 64'(last_rdata));
      end
      while (bq.size() != 0 && bq[0].hi < cyc) void'(bq.pop_front());
      chk("busy", 64'(busy), 64'(bq.size() != 0 && bq[0].lo <= cyc));
    end
  end

  task automatic adv();
    model_step();
    @(negedge clk);
  endtask

  task automatic set_one(input int i, input int id, input int note);
    req[i] = 1'b1;
    req_chart_id[8*i +: 8] = 8'(id);
    req_note_idx[IDX_W*i +: IDX_W] = IDX_W'(note);
  endtask

  task automatic wait_gnt(input int i);
    for (int n = 0; n < 30; n++) begin
      if (gnt[i]) return;
      adv();
    end
    n_checks++;
    n_fail++;
    $display("FAIL gnt_timeout requester %0d: no grant within 30 cycles", i);
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int k = 0; k < n; k++) adv();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_rerr", 64'(rerr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_mem_en", 64'(mem_en), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    gq.delete();
    rq.delete();
    bq.delete();
    last_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    next_arb = cyc;
    mon_en = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = DATA_W'($urandom);
    for (int i = 0; i < MEM_LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    req = '0; req_chart_id = '0; req_note_idx = '0;
    @(negedge clk);
    do_reset();

    // Single read: chart 3 note 5 -> address 197.
    set_one(2, 3, 5);
    wait_gnt(2);
    idle(6);
    // Out-of-range chart id.
    set_one(1, 8, 0);
    wait_gnt(1);
    idle(6);
    // Top of the address space.
    set_one(3, 7, 63);
    wait_gnt(3);
    idle(6);

    // Round-robin among 0,1,3 held from reset.
    do_reset();
    set_one(0, 1, 10); set_one(1, 2, 20); set_one(3, 5, 30);
    for (int k = 0; k < 20; k++) adv();
    idle(6);

    // Reset one cycle after a grant; the pending response must vanish.
    set_one(1, 2, 9);
    wait_gnt(1);
    req = '0;
    adv();
    do_reset();
    idle(5);
    for (int i = 0; i < NUM_REQ; i++) set_one(i, i, i + 1);
    for (int k = 0; k < 12; k++) adv();
    idle(6);

    // Requesters 0 and 1 both always asking.
    set_one(0, 0, 1); set_one(1, 6, 2);
    for (int k = 0; k < 24; k++) adv();
    idle(6);

    // Randomized traffic honouring the hold-until-grant rule.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i]) begin
          if (gnt[i]) begin
            if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
            else set_one(i, int'($urandom_range(0, 9)), int'($urandom_range(0, 63)));
          end else if ($urandom_range(0, 19) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          set_one(i, int'($urandom_range(0, 9)), int'($urandom_range(0, 63)));
        end
      end
      adv();
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
